// File: rtl/pdu_pkg.sv
// pdu_pkg -- shared definitions for the PDU run-control slice.
//   state_t       : run-control FSM state encoding
//   *_DEF         : default values of the pdu_runctl parameters
//   idx_w()       : width of an index into an n-entry table (minimum 1)
package pdu_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  localparam int NBRK_DEF  = 4;
  localparam int AW_DEF    = 32;
  localparam int STEPW_DEF = 16;
  localparam int CNTW_DEF  = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pdu_brk_match.sv
// pdu_brk_match -- NBRK parallel breakpoint comparators with a
// lowest-index priority encoder.
//   pc        : current CPU PC
//   brk_addr  : breakpoint addresses, one per entry
//   brk_en    : breakpoint enables, one per entry
//   any_match : some enabled entry equals pc
//   match_idx : lowest matching entry index (0 when none match)
module pdu_brk_match
  import pdu_pkg::*;
#(
  parameter int NBRK = NBRK_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic [AW-1:0]              pc,
  input  logic [NBRK-1:0][AW-1:0]    brk_addr,
  input  logic [NBRK-1:0]            brk_en,
  output logic                       any_match,
  output logic [idx_w(NBRK)-1:0]     match_idx
);

  localparam int IW = idx_w(NBRK);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves it holding a value and no latch is inferred.
    any_match = 1'b0;
    match_idx = '0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = NBRK - 1; i >= 0; i--) begin
      if (brk_en[i] && (brk_addr[i] == pc)) begin
        any_match = 1'b1;
        match_idx = i[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/pdu_runctl.sv
// pdu_runctl -- PDU run control: stop / single-step burst / free run with
// hardware breakpoints and an executed-cycle counter.
//   clk, rst                  : clock, asynchronous active-high reset
//   step_p, cont_p, halt_p    : single-cycle button pulses
//   step_n                    : instruction count for a step burst (0 acts as 1)
//   pc                        : CPU's current PC
//   brk_we/brk_sel/brk_din/brk_en_din : breakpoint table write port (STOP only)
//   clr_cnt                   : synchronous clear of cyc_cnt
//   cpu_en                    : CPU clock enable
//   stop                      : high while stopped
//   hit_vld, hit_idx          : last stop was a breakpoint hit, and which entry
//   cyc_cnt                   : number of cycles with cpu_en high (wrapping)
module pdu_runctl
  import pdu_pkg::*;
#(
  parameter int NBRK  = NBRK_DEF,
  parameter int AW    = AW_DEF,
  parameter int STEPW = STEPW_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_p,
  input  logic                     cont_p,
  input  logic                     halt_p,
  input  logic [STEPW-1:0]         step_n,
  input  logic [AW-1:0]            pc,
  input  logic                     brk_we,
  input  logic [idx_w(NBRK)-1:0]   brk_sel,
  input  logic [AW-1:0]            brk_din,
  input  logic                     brk_en_din,
  input  logic                     clr_cnt,
  output logic                     cpu_en,
  output logic                     stop,
  output logic                     hit_vld,
  output logic [idx_w(NBRK)-1:0]   hit_idx,
  output logic [CNTW-1:0]          cyc_cnt
);

  localparam int SELW = idx_w(NBRK);

  state_t                  state;
  logic [STEPW-1:0]        rem;
  logic                    first_r;
  logic [NBRK-1:0][AW-1:0] brk_addr;
  logic [NBRK-1:0]         brk_en;
  logic                    any_match;
  logic [SELW-1:0]         match_idx;
  logic                    hit;

  pdu_brk_match #(
    .NBRK (NBRK),
    .AW   (AW)
  ) u_match (
    .pc        (pc),
    .brk_addr  (brk_addr),
    .brk_en    (brk_en),
    .any_match (any_match),
    .match_idx (match_idx)
  );

  // The first RUN cycle is exempt so a resume from a breakpoint PC advances.
  assign hit  = any_match & ~first_r;
  assign stop = (state == ST_STOP);

  // Combinational so a breakpoint or halt stops the CPU in the very cycle
  // it is seen; reset forces STOP asynchronously, which drops cpu_en at once.
  always_comb begin
    cpu_en = 1'b0;
    case (state)
      ST_STEP: cpu_en = 1'b1;
      ST_RUN:  cpu_en = ~(hit | halt_p);
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_STOP;
      rem     <= '0;
      first_r <= 1'b0;
      hit_vld <= 1'b0;
      hit_idx <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      case (state)
        ST_STOP: begin
          if (step_p) begin
            state   <= ST_STEP;
            rem     <= (step_n == '0) ? STEPW'(1) : step_n;
            hit_vld <= 1'b0;
          end else if (cont_p) begin
            state   <= ST_RUN;
            first_r <= 1'b1;
            hit_vld <= 1'b0;
          end
        end
        ST_STEP: begin
          if (halt_p) begin
            state <= ST_STOP;
            rem   <= '0;
          end else begin
            rem <= rem - STEPW'(1);
            if (rem == STEPW'(1)) state <= ST_STOP;
          end
        end
        ST_RUN: begin
          first_r <= 1'b0;
          if (hit || halt_p) begin
            state   <= ST_STOP;
            hit_vld <= hit;
            if (hit) hit_idx <= match_idx;
          end
        end
        default: state <= ST_STOP;
      endcase
    end
  end

  // Breakpoint table: writable only while stopped; out-of-range selects
  // decode to no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the table is reset explicitly -- a stale enabled entry after
      // reset would stop the CPU at an arbitrary PC.
      brk_addr <= '0;
      brk_en   <= '0;
    end else if (brk_we && (state == ST_STOP)) begin
      for (int i = 0; i < NBRK; i++) begin
        if (brk_sel == SELW'(i)) begin
          brk_addr[i] <= brk_din;
          brk_en[i]   <= brk_en_din;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cyc_cnt <= '0;
    else if (clr_cnt) cyc_cnt <= '0;
    else if (cpu_en)  cyc_cnt <= cyc_cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_pdu_runctl.sv
// tb_pdu_runctl -- self-checking bench for pdu_runctl (NBRK=5, CNTW=4 build).
// A behavioural model in the checker process predicts every output each
// cycle; directed sequences add hand-computed literal expectations.
module tb_pdu_runctl;
  import pdu_pkg::*;

  localparam int NBRK  = 5;
  localparam int AW    = 32;
  localparam int STEPW = 16;
  localparam int CNTW  = 4;
  localparam int SELW  = idx_w(NBRK);

  logic             clk = 1'b0;
  logic             rst;
  logic             step_p, cont_p, halt_p;
  logic [STEPW-1:0] step_n;
  logic [AW-1:0]    pc;
  logic             brk_we;
  logic [SELW-1:0]  brk_sel;
  logic [AW-1:0]    brk_din;
  logic             brk_en_din;
  logic             clr_cnt;
  logic             cpu_en, stop, hit_vld;
  logic [SELW-1:0]  hit_idx;
  logic [CNTW-1:0]  cyc_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pdu_runctl #(
    .NBRK (NBRK), .AW (AW), .STEPW (STEPW), .CNTW (CNTW)
  ) dut (
    .clk (clk), .rst (rst),
    .step_p (step_p), .cont_p (cont_p), .halt_p (halt_p),
    .step_n (step_n), .pc (pc),
    .brk_we (brk_we), .brk_sel (brk_sel), .brk_din (brk_din),
    .brk_en_din (brk_en_din), .clr_cnt (clr_cnt),
    .cpu_en (cpu_en), .stop (stop), .hit_vld (hit_vld),
    .hit_idx (hit_idx), .cyc_cnt (cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  bit          m_run;          // free-running
  int          m_left;         // enabled step cycles still owed
  bit          m_guard;        // next RUN cycle ignores breakpoints
  bit          m_hv;
  int          m_hidx;
  int          m_cnt;
  logic [31:0] m_addr [NBRK];
  bit          m_en   [NBRK];
  int          hit_i;
  bit          m_hit, m_stopped, exp_en;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_cpu_en",  cpu_en,  0);
      check("rst_stop",    stop,    1);
      check("rst_hit_vld", hit_vld, 0);
      check("rst_hit_idx", hit_idx, 0);
      check("rst_cyc_cnt", cyc_cnt, 0);
      m_run = 0; m_left = 0; m_guard = 0; m_hv = 0; m_hidx = 0; m_cnt = 0;
      for (int i = 0; i < NBRK; i++) begin m_addr[i] = '0; m_en[i] = 0; end
    end else begin
      m_stopped = !m_run && (m_left == 0);
      hit_i = -1;
      for (int i = 0; i < NBRK; i++)
        if (m_en[i] && m_addr[i] == pc && hit_i < 0) hit_i = i;
      m_hit  = m_run && !m_guard && (hit_i >= 0);
      exp_en = (m_left > 0) ? 1'b1 : (m_run ? !(m_hit || halt_p) : 1'b0);

      check("cpu_en",  cpu_en,  exp_en);
      check("stop",    stop,    m_stopped);
      check("hit_vld", hit_vld, m_hv);
      if (m_hv) check("hit_idx", hit_idx, m_hidx);
      check("cyc_cnt", cyc_cnt, m_cnt);

      // advance the model to the next cycle
      m_cnt = clr_cnt ? 0 : (m_cnt + int'(exp_en)) % (1 << CNTW);
      if (m_stopped && brk_we && int'(brk_sel) < NBRK) begin
        m_addr[brk_sel] = brk_din;
        m_en[brk_sel]   = brk_en_din;
      end
      if (m_stopped) begin
        if (step_p) begin
          m_left = (step_n == 0) ? 1 : int'(step_n);
          m_hv   = 0;
        end else if (cont_p) begin
          m_run = 1; m_guard = 1; m_hv = 0;
        end
      end else if (m_left > 0) begin
        m_left = halt_p ? 0 : m_left - 1;
      end else begin
        m_guard = 0;
        if (m_hit || halt_p) begin
          m_run = 0;
          m_hv  = m_hit;
          if (m_hit) m_hidx = hit_i;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    step_p = 0; cont_p = 0; halt_p = 0; brk_we = 0; clr_cnt = 0;
  endtask

  task automatic wr_brk(input int sel, input logic [31:0] addr, input logic en);
    next_cycle();
    brk_we = 1; brk_sel = SELW'(sel); brk_din = addr; brk_en_din = en;
  endtask

  int unsigned pc_r;

  initial begin
    rst = 1; step_p = 0; cont_p = 0; halt_p = 0; step_n = '0; pc = '0;
    brk_we = 0; brk_sel = '0; brk_din = '0; brk_en_din = 0; clr_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // step_n=3: three enabled cycles from the cycle after the pulse
    next_cycle(); clr_cnt = 1;
    next_cycle(); step_n = 16'd3; step_p = 1;
    @(negedge clk); check("t1_pulse_en", cpu_en, 0); check("t1_pulse_stop", stop, 1);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); @(negedge clk); check("t1_step_en", cpu_en, 1);
    end
    next_cycle(); @(negedge clk);
    check("t1_end_en", cpu_en, 0); check("t1_end_stop", stop, 1); check("t1_end_cnt", cyc_cnt, 3);

    // step_n=0: exactly one enabled cycle
    next_cycle(); clr_cnt = 1; step_n = '0; step_p = 1;
    next_cycle(); @(negedge clk); check("t2_step_en", cpu_en, 1);
    next_cycle(); @(negedge clk);
    check("t2_end_en", cpu_en, 0); check("t2_end_cnt", cyc_cnt, 1);

    // breakpoint hit at 0x10 in entry 2, then resume past it
    wr_brk(2, 32'h10, 1);
    next_cycle(); pc = '0; cont_p = 1;
    for (int p = 0; p < 16; p += 4) begin
      next_cycle(); pc = 32'(p); @(negedge clk); check("t3_run_en", cpu_en, 1);
    end
    next_cycle(); pc = 32'h10; @(negedge clk); check("t3_hit_en", cpu_en, 0);
    next_cycle(); @(negedge clk);
    check("t3_stop", stop, 1); check("t3_hit_vld", hit_vld, 1); check("t3_hit_idx", hit_idx, 2);
    next_cycle(); cont_p = 1;
    next_cycle(); @(negedge clk);
    check("t3_resume_en", cpu_en, 1); check("t3_resume_vld", hit_vld, 0);
    next_cycle(); pc = 32'h14; @(negedge clk); check("t3_adv_en", cpu_en, 1);
    next_cycle(); pc = 32'h18; halt_p = 1; @(negedge clk); check("t3_halt_en", cpu_en, 0);
    next_cycle(); @(negedge clk);
    check("t3_halt_stop", stop, 1); check("t3_halt_vld", hit_vld, 0);

    // entries 1 and 3 share 0x20: lowest index reported
    wr_brk(1, 32'h20, 1);
    wr_brk(3, 32'h20, 1);
    next_cycle(); pc = 32'h18; cont_p = 1;
    next_cycle(); pc = 32'h1C; @(negedge clk); check("t4_run_en", cpu_en, 1);
    next_cycle(); pc = 32'h20; @(negedge clk); check("t4_hit_en", cpu_en, 0);
    next_cycle(); @(negedge clk);
    check("t4_hit_vld", hit_vld, 1); check("t4_hit_idx", hit_idx, 1);

    // a write during RUN is dropped: 0x40 must not stop the CPU
    next_cycle(); cont_p = 1;
    next_cycle(); pc = 32'h24; brk_we = 1; brk_sel = '0; brk_din = 32'h40; brk_en_din = 1;
    next_cycle(); pc = 32'h30;
    next_cycle(); pc = 32'h40; @(negedge clk); check("t5_drop_en", cpu_en, 1);
    next_cycle(); pc = 32'h44; @(negedge clk); check("t5_drop_stop", stop, 0);
    next_cycle(); halt_p = 1;
    // out-of-range selects are ignored
    wr_brk(5, 32'h50, 1);
    wr_brk(7, 32'h50, 1);
    next_cycle(); pc = 32'h4C; cont_p = 1;
    next_cycle(); pc = 32'h50; @(negedge clk); check("t5_oor_en", cpu_en, 1);
    next_cycle(); halt_p = 1;
    for (int s = 0; s < NBRK; s++) wr_brk(s, '0, 0);

    // counter wrap in the 4-bit build: reach 15, two more cycles give 1
    next_cycle(); clr_cnt = 1; step_n = 16'd15; step_p = 1;
    repeat (15) next_cycle();
    next_cycle(); @(negedge clk); check("t6_cnt15", cyc_cnt, 15);
    next_cycle(); step_n = 16'd2; step_p = 1;
    repeat (2) next_cycle();
    next_cycle(); @(negedge clk); check("t6_wrap", cyc_cnt, 1);

    // reset mid-RUN drops cpu_en in the same cycle
    next_cycle(); pc = 32'h100; cont_p = 1;
    next_cycle(); pc = 32'h104; @(negedge clk); check("t7_run_en", cpu_en, 1);
    next_cycle(); pc = 32'h108;
    #1 rst = 1;
    #1;
    check("t7_rst_en", cpu_en, 0); check("t7_rst_stop", stop, 1);
    check("t7_rst_cnt", cyc_cnt, 0); check("t7_rst_vld", hit_vld, 0);
    next_cycle(); rst = 0;
    next_cycle(); @(negedge clk); check("t7_wait_stop", stop, 1); check("t7_wait_en", cpu_en, 0);

    // randomized phase against the model
    pc_r = 0;
    repeat (1500) begin
      next_cycle();
      if ($urandom_range(0, 7) == 0) pc_r = 4 * $urandom_range(0, 15);
      else                           pc_r = (pc_r + 4) % 64;
      pc         = 32'(pc_r);
      step_p     = ($urandom_range(0, 15) == 0);
      cont_p     = ($urandom_range(0, 11) == 0);
      halt_p     = ($urandom_range(0, 31) == 0);
      step_n     = 16'($urandom_range(0, 6));
      brk_we     = ($urandom_range(0, 5) == 0);
      brk_sel    = SELW'($urandom_range(0, (1 << SELW) - 1));
      brk_din    = 32'(4 * $urandom_range(0, 15));
      brk_en_din = ($urandom_range(0, 2) != 0);
      clr_cnt    = ($urandom_range(0, 39) == 0);
    end

    next_cycle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
